stream_burst_source: RTL
========================

Name: stream_burst_source

Overview:
- Transmitter (master) end of the team's valid/ready stream interface.
- Accepts a burst command: base value, step and beat count. Emits that many data beats downstream as an arithmetic sequence, with a last flag on the final beat.
- Sits upstream of node chains and acts as a traffic/pattern generator or simple DMA-style sequencer.
- Obeys the same handshake rules as the receiving nodes: a beat transfers on valid & ready.

Parameters:
- WIDTH, 32, data beat width in bits.
- LEN_W, 8, width of the beat-count field; maximum burst is 2^LEN_W-1 beats.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  burst command valid.
- cmd_ready  output  1  block can accept a command.
- cmd_base  input  WIDTH  first beat value.
- cmd_step  input  WIDTH  increment between consecutive beats.
- cmd_len  input  LEN_W  number of beats in the burst (0 allowed).
- data_out  output  WIDTH  beat data to downstream node.
- valid_down_out  output  1  beat valid to downstream node.
- last_out  output  1  marks final beat of the burst; qualified by valid_down_out.
- ready_down_in  input  1  ready from downstream node.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after burst completion.
- beat_cnt  output  LEN_W  beats transferred so far in the current burst.

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - Output reset values: data_out=0, valid_down_out=0, last_out=0, busy=0, done=0, beat_cnt=0.
  - cmd_ready=1 once reset is released.
  - Reset mid-burst aborts immediately: valid_down_out drops asynchronously and the remaining beats are discarded.
- cmd_fire = cmd_valid & cmd_ready. down_fire = valid_down_out & ready_down_in.
- States: IDLE, SEND, DONE.
- cmd_ready is a decode of IDLE only. It has no combinational path from cmd_valid or ready_down_in.
- IDLE:
  - On cmd_fire with cmd_len != 0: latch step and len. Next cycle: state SEND, data_out=cmd_base, valid_down_out=1, last_out=(cmd_len==1), busy=1, beat_cnt=0.
  - On cmd_fire with cmd_len == 0: no beats are emitted. Go to DONE; done pulses the next cycle.
- SEND:
  - valid_down_out stays 1 until the burst's final down_fire.
  - While valid_down_out=1 and ready_down_in=0, data_out and last_out are held stable.
  - On each down_fire that is not the last beat: data_out <= data_out + step (modulo 2^WIDTH, wrap silently), beat_cnt++, and last_out <= (beat_cnt+2 == len).
  - On down_fire with last_out=1: valid_down_out <= 0, last_out <= 0, beat_cnt <= len, state DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0 in this cycle.
  - Next cycle: state IDLE, done=0, beat_cnt held until the next cmd_fire clears it.
- Latency and throughput:
  - First beat valid 1 cycle after cmd_fire.
  - Back-to-back bursts incur 2 idle cycles (DONE, then IDLE accepting).
  - Full throughput within a burst: 1 beat per cycle when ready_down_in is held high.
- ready_down_in is registered by downstream nodes; this block never waits for ready before raising valid.
- Command inputs are ignored when cmd_ready=0.
- Latched step and len are unaffected by cmd_base, cmd_step or cmd_len changing mid-burst.

Test Plan:
- Basic burst: base=0x10, step=4, len=3, ready held 1 -> beats 0x10, 0x14, 0x18 on consecutive cycles; last_out only on 0x18; done pulses 1 cycle after; cmd_ready returns 2 cycles after the last fire.
- Backpressure: same command, ready pattern 0,0,1,0,1,1 -> data_out holds 0x10 until the first ready, each value stable while ready=0, exactly 3 transfers, no duplicate or skipped beat.
- Wrap and zero length: WIDTH=8, base=0xFE, step=1, len=4 -> 0xFE, 0xFF, 0x00, 0x01. Then len=0 -> no valid, done pulse 1 cycle after cmd_fire.
- Max length and single beat: len=255 with random ready -> 255 transfers, beat_cnt ends at 255, last only on beat 255. len=1 -> one beat with last_out=1 on its first valid cycle.
- Command ignored while busy: cmd_valid held high with new values during a burst -> no acceptance, current sequence unchanged; new command accepted only in IDLE.
- Reset mid-burst: assert rst_n=0 after 2 of 5 beats -> valid_down_out, busy and beat_cnt go 0 immediately; after release, cmd_ready=1 and a new burst runs correctly from its base.

Source files
------------

// File: rtl/stream_burst_source.sv
// stream_burst_source
// Master end of the valid/ready stream interface. A burst command
// (base, step, len) produces len beats forming an arithmetic sequence
// base, base+step, base+2*step, ... with last_out marking the final beat.
// A zero-length command emits no beats and only pulses done.

module stream_burst_source #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // command side
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_base,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [LEN_W-1:0] cmd_len,
  // downstream stream
  output logic [WIDTH-1:0] data_out,
  output logic             valid_down_out,
  output logic             last_out,
  input  logic             ready_down_in,
  // status
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] step_q;
  logic [LEN_W-1:0] len_q;
  logic             cmd_fire;
  logic             down_fire;
  logic [LEN_W:0]   next_idx;

  // Command acceptance is a pure decode of the state register, so there is
  // no combinational path from cmd_valid or ready_down_in to cmd_ready.
  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign down_fire = valid_down_out & ready_down_in;

  // Index of the beat after the one about to transfer, one bit wider so the
  // comparison against len_q cannot wrap.
  assign next_idx  = {1'b0, beat_cnt} + (LEN_W + 1)'(2);

  // Burst sequencer: state, beat generation and all registered outputs.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values; blocking would chain them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      step_q         <= '0;
      len_q          <= '0;
      data_out       <= '0;
      valid_down_out <= 1'b0;
      last_out       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      beat_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_fire) begin
            beat_cnt <= '0;
            if (cmd_len != '0) begin
              step_q         <= cmd_step;
              len_q          <= cmd_len;
              data_out       <= cmd_base;
              valid_down_out <= 1'b1;
              last_out       <= (cmd_len == LEN_W'(1));
              busy           <= 1'b1;
              state          <= SEND;
            end else begin
              // Empty burst: skip straight to the completion pulse.
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        SEND: begin
          // data_out and last_out only move on a transfer, so they stay
          // stable for as long as downstream holds ready low.
          if (down_fire) begin
            if (last_out) begin
              valid_down_out <= 1'b0;
              last_out       <= 1'b0;
              beat_cnt       <= len_q;
              busy           <= 1'b0;
              done           <= 1'b1;
              state          <= DONE;
            end else begin
              data_out <= data_out + step_q;
              beat_cnt <= beat_cnt + LEN_W'(1);
              last_out <= (next_idx == {1'b0, len_q});
            end
          end
        end

        DONE: begin
          // beat_cnt keeps the final count until the next command clears it.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          valid_down_out <= 1'b0;
          last_out       <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
